// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/serial_addsub_fas_bit.sv
// Combinational one-bit full adder/subtractor cell; en selects which pair the caller uses.
module fas_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic en,
    output logic sum,
    output logic carry,
    output logic diff,
    output logic borrow
);

    logic unused_en;

    // Both outputs pairs are always produced; en is carried for interface parity with the cell.
    assign unused_en = en;
    assign sum       = a ^ b ^ cin;
    assign carry     = (a & b) | (cin & (a ^ b));
    assign diff      = a ^ b ^ cin;
    assign borrow    = (~a & b) | (cin & ~(a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract controller: shifts operands LSB first through fas_bit, one bit per clock.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             cy_q, cy_d;
    logic             cout_q, cout_d;

    logic cell_sum, cell_carry, cell_diff, cell_borrow;
    logic bit_res, bit_cy;

    fas_bit u_fas (
        .a      (sa_q[0]),
        .b      (sb_q[0]),
        .cin    (cy_q),
        .en     (op_q),
        .sum    (cell_sum),
        .carry  (cell_carry),
        .diff   (cell_diff),
        .borrow (cell_borrow)
    );

    assign bit_res = (op_q == OP_ADD) ? cell_sum   : cell_diff;
    assign bit_cy  = (op_q == OP_ADD) ? cell_carry : cell_borrow;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        cy_d    = cy_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    op_d    = en;
                    cy_d    = cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Result enters at the MSB so it is aligned after the final bit.
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                res_d = {bit_res, res_q[WIDTH-1:1]};
                cy_d  = bit_cy;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    cout_d  = bit_cy;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            cy_q    <= cy_d;
            cout_q  <= cout_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = res_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: driver queues expected results, monitor checks on done.
module tb_serial_addsub;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic [31:0]  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         en;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] cyc   = 0;
    exp_t        expq[$];

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .en     (en),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic op, input logic c);
        int unsigned ix, iy, r;
        ix = x;
        iy = y;
        if (op) begin
            r = ix + iy + c;
            return r[W:0];
        end
        r = (ix - iy - c) & ((1 << W) - 1);
        return {(ix < iy + c), r[W-1:0]};
    endfunction

    function automatic exp_t make_exp(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic op, input logic c, input logic [31:0] at);
        exp_t e;
        logic [W:0] m;
        m = model(x, y, op, c);
        e.res  = m[W-1:0];
        e.cout = m[W];
        e.cyc  = at;
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse; also checks pulse width and busy length.
    int   busy_len  = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_len  = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (prev_done) check("done_width", 32'd2, 32'd1);
                if (expq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("latency", cyc, e.cyc);
                end
            end
            if (busy) busy_len++;
            else if (busy_len != 0) begin
                check("busy_len", busy_len, W + 1);
                busy_len = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic op, input logic c);
        wait_idle();
        a = x; b = y; en = op; cin = c; start = 1'b1;
        expq.push_back(make_exp(x, y, op, c, cyc + 1 + W));
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] n0;
        int          guard;
        rst = 1'b1; start = 1'b0; en = 1'b1; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        issue(8'h35, 8'h4A, 1'b1, 1'b0);
        issue(8'hFF, 8'h01, 1'b1, 1'b0);
        issue(8'h00, 8'h00, 1'b1, 1'b1);
        issue(8'h10, 8'h01, 1'b0, 1'b0);
        issue(8'h01, 8'h02, 1'b0, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("result_hold", 32'(result), 32'hFF);
        check("cout_hold", 32'(cout), 32'd1);

        // Start held high through RUN with changed operands: only the IDLE start takes effect.
        wait_idle();
        a = 8'h12; b = 8'h34; en = 1'b1; cin = 1'b0; start = 1'b1;
        n0 = cyc + 1;
        expq.push_back(make_exp(8'h12, 8'h34, 1'b1, 1'b0, n0 + W));
        @(negedge clk);
        a = 8'hC3; b = 8'h5A; en = 1'b0; cin = 1'b1;
        expq.push_back(make_exp(8'hC3, 8'h5A, 1'b0, 1'b1, n0 + 2 * W + 2));
        while (cyc < n0 + W + 2) @(negedge clk);
        start = 1'b0;

        // Reset on the fourth RUN cycle aborts the operation without a done.
        wait_idle();
        a = 8'hAA; b = 8'h55; en = 1'b1; cin = 1'b1; start = 1'b1;
        expq.push_back(make_exp(8'hAA, 8'h55, 1'b1, 1'b1, cyc + 1 + W));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        void'(expq.pop_back());
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        issue(8'h7E, 8'h81, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        guard = 0;
        while (expq.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 32'(expq.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
